banked_data_mem: RTL and testbench
==================================

Name: banked_data_mem

Overview:
- Parametrised, multi-requester, word-organised data memory. Successor to the single-port combinational-read memory.
- Adds per-port valid/ready request handshake, round-robin arbitration onto one internal array, and byte-strobed writes.
- Adds registered (1-cycle) reads, write acknowledge, and error responses for misaligned or out-of-range addresses.
- Sits between the core's load/store unit(s) and the backing array; can be preloaded from a hex file.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width presented by requesters.
- DEPTH_LOG2, 10, log2 of the number of words in the array.
- NUM_PORTS, 2, number of requester channels (1..8).
- INIT_FILE, "prog2_mem.hex", $readmemh preload file; "" means no preload.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port request present.
- req_ready  out  NUM_PORTS  per-port request accepted this cycle.
- req_write  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  byte address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  write data.
- req_be  in  NUM_PORTS*(DATA_WIDTH/8)  write byte enables.
- rsp_valid  out  NUM_PORTS  one-cycle response pulse.
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  read data; 0 when rsp_valid is low, or for write and error responses.
- rsp_err  out  NUM_PORTS  response is an error; qualified by rsp_valid.

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_rdata=0, rsp_err=0, arbiter pointer=0. Array contents are not cleared.
- On reset mid-operation, any pending response is dropped.
- Word index = req_addr[DEPTH_LOG2+1:2]. No tri-state outputs; unused outputs drive 0.
- Arbitration:
  - Exactly one request is accepted per cycle.
  - Grant goes to the first port with req_valid set, searching from the pointer upward with wrap-around.
  - req_ready is combinational: high only for the granted port, and only when its req_valid is high.
  - The pointer advances to (granted+1) mod NUM_PORTS after each accept and holds when nothing is accepted.
- Handshake:
  - Requesters hold valid, write, addr, wdata and be stable until ready is seen.
  - A transfer occurs when valid and ready are both high at the rising edge.
- Error check, evaluated at accept:
  - Misaligned: addr[1:0] != 0.
  - Out of range: any addr bit above DEPTH_LOG2+1 is set.
  - An error accept performs no array access. The following cycle gives rsp_valid=1, rsp_err=1, rsp_rdata=0 on that port.
- Read: accepted in cycle N. In cycle N+1 the port sees rsp_valid=1, rsp_err=0, rsp_rdata = array word as of the end of cycle N.
- Write:
  - Byte k of the word is updated at the accepting edge iff be[k]=1.
  - In cycle N+1: rsp_valid=1, rsp_err=0, rsp_rdata=0.
  - be=0 is legal: no change, still acknowledged.
- Responses have no backpressure. At most one port has rsp_valid high per cycle.
- Back-to-back operations:
  - A read accepted the cycle after a write to the same word returns the written data.
  - A port may be accepted in consecutive cycles only when it is the sole requester.
- Throughput: 1 access/cycle aggregate. A port waits at most NUM_PORTS-1 cycles while continuously valid.

Decomposition:
- Package definitions:
  - mem_req_t {write, addr, wdata, be} and mem_rsp_t {valid, rdata, err}.
  - ENABLE/DISABLE constants.
  - Default MemAddrWidth, which matches DEPTH_LOG2.
- One sub-module: rr_arbiter (NUM_PORTS parameter; valid vector and advance in, one-hot grant out, pointer register with async active-low reset).
- The array, error check, byte-merge and response register stay in banked_data_mem.

Test Plan:
- Reset then single port 0: write 0xDEADBEEF to 0x10 with be=0xF; next cycle read 0x10 -> write ack rsp_err=0, rsp_rdata=0; read response rsp_rdata=0xDEADBEEF one cycle after accept.
- Byte strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD be=0x5 -> read returns 0x11BB33DD.
- Contention: ports 0 and 1 both continuously valid with reads from a fresh reset -> grants alternate 0,1,0,1; each rsp_valid pulse arrives exactly one cycle after its ready; never two rsp_valid in the same cycle.
- Errors: read 0x6 -> rsp_err=1, rdata=0. Write 0x1000 with DEPTH_LOG2=10 -> rsp_err=1. A subsequent read of word 0 shows it unmodified.
- Reset mid-operation: assert rst_n low asynchronously in the cycle after a read accept -> rsp_valid stays 0 immediately with no response; arbiter restarts at port 0.
- Preload: with INIT_FILE set, read 0x0 right after reset -> first hex word of the file.

Source files
------------

// File: rtl/banked_data_mem_pkg.sv
// Shared types and constants for the banked data memory and its requesters.
package banked_data_mem_pkg;

  localparam int unsigned MemDataWidth = 32;
  localparam int unsigned ReqAddrWidth = 32;
  localparam int unsigned MemAddrWidth = 10;
  localparam int unsigned MemBeWidth   = MemDataWidth / 8;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef struct packed {
    logic                    write;
    logic [ReqAddrWidth-1:0] addr;
    logic [MemDataWidth-1:0] wdata;
    logic [MemBeWidth-1:0]   be;
  } mem_req_t;

  typedef struct packed {
    logic                    valid;
    logic [MemDataWidth-1:0] rdata;
    logic                    err;
  } mem_rsp_t;

endpackage

// File: rtl/banked_data_mem_if.sv
// Multi-port request/response bus between load/store units and the data memory.
interface banked_data_mem_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS*BeWidth-1:0]    req_be;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata;
  logic [NUM_PORTS-1:0]            rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/banked_data_mem_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid port at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] valid_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] grant_c_o
);
  localparam int unsigned PtrWidth = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic [PtrWidth-1:0] idx_c, win_c;
  logic                found_c;

  // Search from the pointer upward with wrap-around; pick the first valid port.
  always_comb begin
    found_c   = 1'b0;
    win_c     = '0;
    idx_c     = '0;
    grant_c_o = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx_c = PtrWidth'((32'(ptr_q) + i) % NUM_PORTS);
      if (!found_c && valid_i[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
    if (found_c) grant_c_o[win_c] = 1'b1;
  end

  // Pointer moves just past the winner on each accept, otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found_c) begin
      ptr_d = (win_c == PtrWidth'(NUM_PORTS - 1)) ? '0 : win_c + PtrWidth'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/banked_data_mem.sv
// Multi-requester word memory: round-robin accept, byte-strobed writes,
// registered one-cycle responses with error reporting.
module banked_data_mem
  import banked_data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MemDataWidth,
  parameter int unsigned ADDR_WIDTH = ReqAddrWidth,
  parameter int unsigned DEPTH_LOG2 = MemAddrWidth,
  parameter int unsigned NUM_PORTS  = 2,
  parameter string       INIT_FILE  = "prog2_mem.hex"
) (
  input logic                 clk,
  input logic                 rst_n,
  banked_data_mem_if.slave    bus
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned Depth   = 32'(1) << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [NUM_PORTS-1:0]  grant_c;
  logic                  accept_c;
  logic                  sel_write_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic [BeWidth-1:0]    sel_be_c;
  logic                  err_c;
  logic                  wr_en_c;
  logic [DEPTH_LOG2-1:0] word_idx_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  logic [NUM_PORTS-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS-1:0]            rsp_err_q, rsp_err_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (bus.req_valid),
    .advance_i (accept_c),
    .grant_c_o (grant_c)
  );

  // The arbiter only grants valid ports, so any grant is an accept.
  assign accept_c      = |grant_c;
  assign bus.req_ready = grant_c & bus.req_valid;

  // Steer the granted port's request onto the shared array path.
  always_comb begin
    sel_write_c = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_be_c    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_c[p]) begin
        sel_write_c = bus.req_write[p];
        sel_addr_c  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_c = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_be_c    = bus.req_be[p*BeWidth +: BeWidth];
      end
    end
  end

  // Misaligned or beyond the array: no array access, error response instead.
  assign err_c      = (|sel_addr_c[1:0]) | (|(sel_addr_c >> (DEPTH_LOG2 + 2)));
  assign word_idx_c = sel_addr_c[DEPTH_LOG2+1:2];
  assign rd_word_c  = mem_q[word_idx_c];
  assign wr_en_c    = accept_c & sel_write_c & ~err_c;

  // Byte-merged array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int unsigned k = 0; k < BeWidth; k++) begin
        if (sel_be_c[k]) mem_q[word_idx_c][k*8 +: 8] <= sel_wdata_c[k*8 +: 8];
      end
    end
  end

  // Build next-cycle response for the accepted port only.
  always_comb begin
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    rsp_rdata_d = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_c[p]) begin
        rsp_valid_d[p] = ENABLE;
        rsp_err_d[p]   = err_c ? ENABLE : DISABLE;
        if (!err_c && !sel_write_c) rsp_rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_word_c;
      end
    end
  end

  // Response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_banked_data_mem.sv
// Self-checking bench for banked_data_mem with a word-array reference model.
module tb_banked_data_mem;
  localparam int unsigned NP = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DL = 10;

  logic clk = 1'b0;
  logic rst_n;

  banked_data_mem_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  banked_data_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .NUM_PORTS(NP), .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [0:1023];

  // Reference: byte address -> error flag, read data, and array update.
  function automatic void ref_access(input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [3:0] be,
                                     output bit err, output logic [31:0] rd);
    int unsigned idx;
    err = (addr % 4 != 0) || (addr >= 32'd4096);
    rd  = '0;
    if (!err) begin
      idx = addr / 4;
      if (wr) begin
        for (int k = 0; k < 4; k++) if (be[k]) ref_mem[idx][k*8 +: 8] = wd[k*8 +: 8];
      end else begin
        rd = ref_mem[idx];
      end
    end
  endfunction

  task automatic idle();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.req_valid[p]             = 1'b1;
    bus.req_write[p]             = wr;
    bus.req_addr[p*AW +: AW]     = addr;
    bus.req_wdata[p*DW +: DW]    = wd;
    bus.req_be[p*4 +: 4]         = be;
  endtask

  // Single-port access, called just after a rising edge; checks the response.
  task automatic access(input int p, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string tag,
                        output logic [31:0] got_rd);
    bit got;
    bit eerr;
    logic [31:0] erd;
    logic [NP-1:0] ev;
    logic [NP*DW-1:0] erd_all;
    got = 1'b0;
    got_rd = '0;
    drive(p, wr, addr, wd, be);
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[p] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s ready_timeout port %0d ready=%b", tag, p, bus.req_ready);
      idle();
      return;
    end
    @(posedge clk);
    #1;
    idle();
    ref_access(wr, addr, wd, be, eerr, erd);
    ev = '0; ev[p] = 1'b1;
    erd_all = '0; erd_all[p*DW +: DW] = erd;
    got_rd = bus.rsp_rdata[p*DW +: DW];
    n_cmp++;
    if (bus.rsp_valid !== ev) begin
      n_bad++; $display("FAIL %s rsp_valid got %b exp %b", tag, bus.rsp_valid, ev);
    end
    n_cmp++;
    if (bus.rsp_err !== (eerr ? ev : '0)) begin
      n_bad++; $display("FAIL %s rsp_err got %b exp_err %0d", tag, bus.rsp_err, eerr);
    end
    n_cmp++;
    if (bus.rsp_rdata !== erd_all) begin
      n_bad++; $display("FAIL %s rsp_rdata got %h exp %h", tag, bus.rsp_rdata, erd_all);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    n_cmp++;
    if (bus.rsp_valid !== '0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", bus.rsp_valid); end
    n_cmp++;
    if (bus.rsp_err !== '0) begin n_bad++; $display("FAIL reset_err got %b exp 0", bus.rsp_err); end
    n_cmp++;
    if (bus.rsp_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", bus.rsp_rdata); end
    n_cmp++;
    if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got %b exp 0", bus.req_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_deadbeef", rd);
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, "rd_deadbeef", rd);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_after_wr got %h exp deadbeef", rd); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd;
    access(1, 1'b1, 32'h20, 32'h11223344, 4'hF, "bs_init", rd);
    access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, "bs_write", rd);
    access(1, 1'b0, 32'h20, 32'h0, 4'h0, "bs_read", rd);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin n_bad++; $display("FAIL byte_strobe got %h exp 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    access(0, 1'b1, 32'h0, 32'h5A5A0001, 4'hF, "err_init", rd);
    access(0, 1'b0, 32'h6, 32'h0, 4'h0, "err_misaligned_rd", rd);
    access(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, "err_range_wr", rd);
    access(1, 1'b1, 32'h3, 32'hFFFFFFFF, 4'hF, "err_misaligned_wr", rd);
    access(1, 1'b0, 32'h80000000, 32'h0, 4'h0, "err_range_rd", rd);
    access(1, 1'b1, 32'h0, 32'h12345678, 4'h0, "be_zero_wr", rd);
    access(0, 1'b0, 32'h0, 32'h0, 4'h0, "err_word0_rd", rd);
    n_cmp++;
    if (rd !== 32'h5A5A0001) begin n_bad++; $display("FAIL word0_unmodified got %h exp 5a5a0001", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr;
    int unsigned w, r;
    for (int i = 0; i < 16; i++) begin
      access(i % 2, 1'b1, 32'(i * 4), $urandom, 4'hF, "rnd_init", rd);
    end
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 15);
      r = $urandom_range(0, 7);
      if (r == 0)      addr = 32'(w * 4 + $urandom_range(1, 3));
      else if (r == 1) addr = 32'h1000 + 32'(w * 4) + ($urandom_range(0, 1) == 1 ? 32'h40000000 : 32'h0);
      else             addr = 32'(w * 4);
      access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
             4'($urandom_range(0, 15)), "rnd_access", rd);
      if ($urandom_range(0, 3) == 0) sync();
    end
  endtask

  task automatic test_contention();
    int unsigned eg;
    logic [31:0] a [NP];
    logic [31:0] erd;
    logic [NP-1:0] oh;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    sync();
    for (int p = 0; p < int'(NP); p++) begin
      a[p] = 32'($urandom_range(0, 15) * 4);
      drive(p, 1'b0, a[p], 32'h0, 4'h0);
    end
    for (int c = 0; c < 8; c++) begin
      eg = c % 2;
      oh = '0; oh[eg] = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== oh) begin
        n_bad++; $display("FAIL cont_ready cycle %0d got %b exp %b", c, bus.req_ready, oh);
      end
      erd = ref_mem[a[eg] / 4];
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rsp_valid !== oh) begin
        n_bad++; $display("FAIL cont_rsp_valid cycle %0d got %b exp %b", c, bus.rsp_valid, oh);
      end
      n_cmp++;
      if (bus.rsp_rdata[eg*DW +: DW] !== erd || bus.rsp_rdata[(1-eg)*DW +: DW] !== '0) begin
        n_bad++; $display("FAIL cont_rdata cycle %0d got %h exp port%0d=%h", c, bus.rsp_rdata, eg, erd);
      end
      a[eg] = 32'($urandom_range(0, 15) * 4);
      bus.req_addr[eg*AW +: AW] = a[eg];
    end
    idle();
    sync();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    access(0, 1'b0, 32'h4, 32'h0, 4'h0, "mid_pre", rd);
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_ready got %b exp 01", bus.req_ready); end
    @(posedge clk);
    #1;
    idle();
    n_cmp++;
    if (bus.rsp_valid !== 2'b01) begin n_bad++; $display("FAIL mid_pending got %b exp 01", bus.rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.rsp_valid !== '0 || bus.rsp_rdata !== '0) begin
      n_bad++; $display("FAIL mid_reset_drop got valid %b rdata %h exp 0", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0);
    drive(1, 1'b0, 32'hC, 32'h0, 4'h0);
    #1;
    n_cmp++;
    if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL mid_restart_ready got %b exp 01", bus.req_ready); end
    @(posedge clk);
    #1;
    idle();
    n_cmp++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata[31:0] !== ref_mem[2]) begin
      n_bad++; $display("FAIL mid_restart_rsp got valid %b rdata %h exp 01 %h", bus.rsp_valid, bus.rsp_rdata, ref_mem[2]);
    end
    sync();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_errors();
    test_random();
    test_contention();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
